// File: rtl/palindrome_gen.sv
// palindrome_gen: after a start request, emits every WIDTH-bit binary
// palindrome in ascending order, starting from a seed half-word. Words go
// out one per valid/ready handshake.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; out_valid low
// S_GEN  | presenting pal_out; advances on each handshake, abort returns
// S_DONE | final word has transferred; done high for this single cycle
//
// pal_out is rebuilt from the half value each time the half register is
// loaded. This keeps every output a plain flop, so out_ready never has a
// combinational path to any output.

module palindrome_gen #(
  parameter  int WIDTH = 8,
  localparam int HALF  = (WIDTH + 1) / 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [HALF-1:0]   seed,
  input  logic              abort,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  pal_out,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic [HALF:0]     emit_cnt
);

  // The low part mirrors only the top LOW bits of the half word. For odd
  // WIDTH the half's LSB is the centre bit and is not mirrored.
  localparam int LOW = WIDTH - HALF;

  localparam logic [HALF-1:0] HALF_ONES = '1;
  localparam logic [HALF-1:0] HALF_INC  = HALF'(1);
  localparam logic [HALF:0]   CNT_INC   = (HALF + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GEN,
    S_DONE
  } state_t;

  state_t          state;
  logic [HALF-1:0] half;
  logic [HALF-1:0] half_next;
  logic            xfer;

  function automatic logic [WIDTH-1:0] mirror(input logic [HALF-1:0] h);
    logic [WIDTH-1:0] w;
    w = '0;
    w[WIDTH-1 -: HALF] = h;
    for (int i = 0; i < LOW; i++) begin
      w[i] = h[HALF-1-i];
    end
    return w;
  endfunction

  assign half_next = half + HALF_INC;
  assign xfer      = out_valid && out_ready;

  // Sequencer: half register, handshake counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      half      <= '0;
      out_valid <= 1'b0;
      pal_out   <= '0;
      last      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      emit_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= S_GEN;
            half      <= seed;
            pal_out   <= mirror(seed);
            last      <= (seed == HALF_ONES);
            out_valid <= 1'b1;
            busy      <= 1'b1;
            emit_cnt  <= '0;
          end
        end

        S_GEN: begin
          if (abort) begin
            // The word on the bus this cycle does not count as transferred.
            state     <= S_IDLE;
            out_valid <= 1'b0;
            last      <= 1'b0;
            busy      <= 1'b0;
          end else if (xfer) begin
            emit_cnt <= emit_cnt + CNT_INC;
            if (last) begin
              // The half register stays at all ones rather than wrapping.
              state     <= S_DONE;
              out_valid <= 1'b0;
              last      <= 1'b0;
              done      <= 1'b1;
            end else begin
              half    <= half_next;
              pal_out <= mirror(half_next);
              last    <= (half_next == HALF_ONES);
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          last      <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
